// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory access unit (optional address check: MEM_ACCESS_CHECK_EN).
package mem_pkg;

  localparam int DEPTH_DEF  = 512;
  localparam int DATA_W_DEF = 32;

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

  localparam int IDX_W_DEF = idx_width(DEPTH_DEF);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

endpackage

// File: rtl/mem_access_unit_addr_check.sv
// Combinational address validator; only instantiated when MEM_ACCESS_CHECK_EN is defined.
module mem_addr_check #(
  parameter int DEPTH  = 512,
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] addr_i,
  output logic              err_o
);

  localparam logic [DATA_W-1:0] LIMIT = DATA_W'(4 * DEPTH);

  always_comb begin
    err_o = (addr_i[1:0] != 2'b00) || (addr_i >= LIMIT);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store sequencer between a pipeline and a registered-read memory.
// Optional address rejection is compiled in with MEM_ACCESS_CHECK_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_active,
  output logic              mem_rw,
  output logic [DATA_W-1:0] mem_index,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int IDX_W = idx_width(DEPTH);

  state_e            state_q, state_d;
  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              addr_err;
  logic              accept;

`ifdef MEM_ACCESS_CHECK_EN
  mem_addr_check #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_addr_check (
    .addr_i (req_addr),
    .err_o  (addr_err)
  );
`else
  // Without the check, address bits outside the word index are simply dropped.
  logic unused_addr_bits;
  assign addr_err         = 1'b0;
  assign unused_addr_bits = ^{req_addr[DATA_W-1:IDX_W+2], req_addr[1:0]};
`endif

  assign accept = req_valid && (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = addr_err ? RESP : ISSUE;
      ISSUE:   state_d = we_q ? RESP : CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    mem_active = (state_q == ISSUE);
  end

  // Request fields stay latched from accept until the next accept so the memory side is stable through RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we;
      idx_q   <= req_addr[IDX_W+1:2];
      wdata_q <= req_wdata;
      rdata_q <= '0;
      err_q   <= addr_err;
    end else if (state_q == CAPTURE) begin
      rdata_q <= mem_rdata;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_rw     = we_q;
  assign mem_index  = DATA_W'(idx_q);
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit; honours MEM_ACCESS_CHECK_EN if defined.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int DEPTH  = DEPTH_DEF;
  localparam int DATA_W = DATA_W_DEF;
  localparam int IDX_W  = IDX_W_DEF;
`ifdef MEM_ACCESS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [DATA_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_active;
  logic              mem_rw;
  logic [DATA_W-1:0] mem_index;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_active (mem_active),
    .mem_rw     (mem_rw),
    .mem_index  (mem_index),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Attached memory: read data registered at the edge that samples mem_active.
  always @(posedge clk) begin
    if (mem_active) begin
      if (mem_rw) mem[mem_index[IDX_W-1:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_index[IDX_W-1:0]];
    end
  end

  function automatic int ref_idx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic bit ref_bad(input logic [31:0] a);
    return CHK && ((a % 4) != 0 || a >= 4 * DEPTH);
  endfunction

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold, output int lat, output logic [31:0] rdata,
                         output logic err, output int act, output logic [31:0] idx,
                         output logic rw, output logic [31:0] wd, output logic stable,
                         output logic ready_low, output logic done);
    int n;
    done = 0; lat = 0; act = 0; rdata = '0; err = 0; idx = '0; rw = 0; wd = '0;
    stable = 1; ready_low = 1;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 0;
    n = 0;
    while (n < 20) begin
      if (mem_active) act++;
      if (resp_valid) break;
      @(posedge clk); lat++;
      @(negedge clk); n++;
    end
    if (resp_valid) begin
      done = 1; rdata = resp_rdata; err = resp_err; idx = mem_index; rw = mem_rw; wd = mem_wdata;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (!resp_valid || resp_rdata !== rdata || resp_err !== err) stable = 0;
        if (req_ready) ready_low = 0;
        if (mem_active) act++;
      end
      resp_ready = 1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    if (resp_valid !== 1'b0) begin $display("FAIL reset_resp_valid: got %b want 0", resp_valid); n_fail++; end
    n_checks++;
    if (resp_rdata !== '0) begin $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); n_fail++; end
    n_checks++;
    if (resp_err !== 1'b0) begin $display("FAIL reset_resp_err: got %b want 0", resp_err); n_fail++; end
    n_checks++;
    if (mem_active !== 1'b0) begin $display("FAIL reset_mem_active: got %b want 0", mem_active); n_fail++; end
    n_checks++;
    if ({mem_rw, mem_index, mem_wdata} !== '0) begin
      $display("FAIL reset_mem_side: got rw=%b idx=%h wd=%h want 0", mem_rw, mem_index, mem_wdata); n_fail++;
    end
    n_checks++;
    rst_n = 1;
    @(negedge clk);
    if (req_ready !== 1'b1) begin $display("FAIL reset_req_ready: got %b want 1", req_ready); n_fail++; end
    n_checks++;
  endtask

  task automatic test_store_load();
    int lat, act; logic [31:0] rd, idx, wd; logic err, rw, st, rl, dn;
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 0, lat, rd, err, act, idx, rw, wd, st, rl, dn);
    ref_mem[4] = 32'hDEADBEEF;
    if (!dn || lat !== 2) begin $display("FAIL store_latency: got %0d want 2", lat); n_fail++; end
    n_checks++;
    if (act !== 1) begin $display("FAIL store_active_cycles: got %0d want 1", act); n_fail++; end
    n_checks++;
    if (idx !== 32'd4 || rw !== 1'b1 || wd !== 32'hDEADBEEF) begin
      $display("FAIL store_mem_side: got idx=%h rw=%b wd=%h want 4/1/deadbeef", idx, rw, wd); n_fail++;
    end
    n_checks++;
    if (rd !== '0 || err !== 1'b0) begin $display("FAIL store_resp: got rdata=%h err=%b want 0/0", rd, err); n_fail++; end
    n_checks++;
    run_txn(1'b0, 32'h10, 32'h0, 0, lat, rd, err, act, idx, rw, wd, st, rl, dn);
    if (!dn || lat !== 3) begin $display("FAIL load_latency: got %0d want 3", lat); n_fail++; end
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin $display("FAIL load_rdata: got %h want deadbeef", rd); n_fail++; end
    n_checks++;
    if (act !== 1 || rw !== 1'b0 || idx !== 32'd4) begin
      $display("FAIL load_mem_side: got act=%0d rw=%b idx=%h want 1/0/4", act, rw, idx); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_resp_hold();
    int lat, act; logic [31:0] rd, idx, wd; logic err, rw, st, rl, dn;
    run_txn(1'b0, 32'h10, 32'h0, 5, lat, rd, err, act, idx, rw, wd, st, rl, dn);
    if (!dn || st !== 1'b1) begin $display("FAIL hold_stable: got %b want 1", st); n_fail++; end
    n_checks++;
    if (rl !== 1'b1) begin $display("FAIL hold_req_ready_low: got %b want 1", rl); n_fail++; end
    n_checks++;
    if (rd !== ref_mem[4] || act !== 1) begin
      $display("FAIL hold_rdata: got %h act=%0d want %h act=1", rd, act, ref_mem[4]); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_random();
    int lat, act, ei, elat; logic [31:0] rd, idx, wd, a, d, erd; logic err, rw, st, rl, dn, we, eerr;
    for (int s = 0; s < 8; s++) begin
      d = $urandom;
      run_txn(1'b1, 32'(s * 64 * 4), d, 0, lat, rd, err, act, idx, rw, wd, st, rl, dn);
      ref_mem[s * 64] = d;
    end
    for (int t = 0; t < 40; t++) begin
      we = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 7) * 64 * 4);
      if (!CHK) a = a | ($urandom & 32'hFFFF_F800) | 32'($urandom_range(0, 3));
      else if ($urandom_range(0, 4) == 0) a = a | 32'h1;
      d = $urandom;
      eerr = ref_bad(a);
      ei   = ref_idx(a);
      elat = eerr ? 1 : (we ? 2 : 3);
      erd  = (eerr || we) ? 32'h0 : ref_mem[ei];
      if (!eerr && we) ref_mem[ei] = d;
      run_txn(we, a, d, int'($urandom_range(0, 2)), lat, rd, err, act, idx, rw, wd, st, rl, dn);
      if (!dn || lat !== elat || rd !== erd || err !== eerr || act !== (eerr ? 0 : 1) || st !== 1'b1) begin
        $display("FAIL random_txn[%0d]: got lat=%0d rdata=%h err=%b act=%0d stable=%b want lat=%0d rdata=%h err=%b act=%0d stable=1",
                 t, lat, rd, err, act, st, elat, erd, eerr, eerr ? 0 : 1);
        n_fail++;
      end
      n_checks++;
      if (!eerr && idx !== 32'(ei)) begin $display("FAIL random_index[%0d]: got %h want %h", t, idx, ei); n_fail++; end
      n_checks++;
    end
  endtask

  task automatic test_bad_addr();
    int lat, act; logic [31:0] rd, idx, wd, erd; logic err, rw, st, rl, dn, eerr;
    eerr = ref_bad(32'h802);
    erd  = eerr ? 32'h0 : ref_mem[ref_idx(32'h802)];
    run_txn(1'b0, 32'h802, 32'h0, 0, lat, rd, err, act, idx, rw, wd, st, rl, dn);
    if (!dn || err !== eerr || lat !== (eerr ? 1 : 3)) begin
      $display("FAIL bad_addr_resp: got err=%b lat=%0d want err=%b lat=%0d", err, lat, eerr, eerr ? 1 : 3); n_fail++;
    end
    n_checks++;
    if (act !== (eerr ? 0 : 1) || rd !== erd) begin
      $display("FAIL bad_addr_access: got act=%0d rdata=%h want act=%0d rdata=%h", act, rd, eerr ? 0 : 1, erd); n_fail++;
    end
    n_checks++;
    if (!eerr && idx !== 32'd0) begin $display("FAIL bad_addr_index: got %h want 0", idx); n_fail++; end
    n_checks++;
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL midreset_state: got resp_valid=%b req_ready=%b want 0/1", resp_valid, req_ready); n_fail++;
    end
    n_checks++;
    if (resp_rdata !== '0 || mem_index !== '0) begin
      $display("FAIL midreset_regs: got rdata=%h idx=%h want 0/0", resp_rdata, mem_index); n_fail++;
    end
    n_checks++;
    seen = 0;
    resp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid || mem_active) seen = 1;
    end
    resp_ready = 0;
    if (seen !== 1'b0) begin $display("FAIL midreset_no_resp: got activity=%b want 0", seen); n_fail++; end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    int cyc, acc1, acc2, exit1, n; logic overlap;
    acc1 = -1; acc2 = -1; exit1 = -1; overlap = 0;
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 32'h100; req_wdata = 32'hA5A5_0001; resp_ready = 1;
    ref_mem[64] = 32'hA5A5_0001;
    for (cyc = 0; cyc < 12; cyc++) begin
      if (req_valid && req_ready) begin
        if (acc1 < 0) acc1 = cyc; else if (acc2 < 0) acc2 = cyc;
      end
      if (resp_valid && resp_ready) begin
        if (exit1 < 0) exit1 = cyc;
        if (req_ready) overlap = 1;
      end
      @(negedge clk);
    end
    req_valid = 0;
    n = 0;
    while (!(req_ready && !resp_valid) && n < 10) begin @(negedge clk); n++; end
    resp_ready = 0;
    if (acc1 !== 0 || exit1 !== 2) begin
      $display("FAIL b2b_first: got accept=%0d exit=%0d want 0/2", acc1, exit1); n_fail++;
    end
    n_checks++;
    if (acc2 !== exit1 + 1) begin $display("FAIL b2b_second_accept: got %0d want %0d", acc2, exit1 + 1); n_fail++; end
    n_checks++;
    if (overlap !== 1'b0 || n >= 10) begin
      $display("FAIL b2b_overlap: got overlap=%b drain=%0d want 0/<10", overlap, n); n_fail++;
    end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_resp_hold();
    test_random();
    test_bad_addr();
    test_reset_mid();
    test_back_to_back();
    test_store_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
